smi_request_arbiter_x4: RTL and testbench

- Shares one SMI request/response port pair, normally the combined read/write AXI bus adaptor, between four upstream SMI requesters.
- Request side: frame-atomic round-robin arbitration. Each request header is tagged with the requester index.
- Response side: each response frame is routed back to the requester named by its header tag.
- Sits between kernel-side SMI clients and the bus adaptor.

---
 rtl/smi_request_arbiter_x4.sv | 229 ++++++++++++++++++++++
 tb/tb_smi_request_arbiter_x4.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smi_request_arbiter_x4.sv
// -----------------------------------------------------------------------------
// smi_request_arbiter_x4
//
// Shares one SMI request/response port pair (normally the combined read/write
// AXI bus adaptor) between four upstream SMI requesters.
//   - Request side: frame-atomic round-robin arbitration. The header flit of
//     each granted frame has byte 1 overwritten with the requester index.
//   - Response side: each response frame is steered back to the requester named
//     by header bits [9:8]; data/eofc are broadcast, only Ready is steered.
// The request and response paths are fully independent.
//
// Optional feature macro: SMI_ARB_OUTSTANDING_LIMIT_EN
//   When defined, an outstanding-frame counter stops new grants while
//   MaxOutstanding request frames are waiting for their final response flit.
//
// Ports:
//   clk, arstn       clock, asynchronous active-low reset
//   smiInReq*        four upstream request ports (Ready/Eofc/Data in, Stop out)
//   smiInResp*       four upstream response ports (Ready out, Stop in),
//                    Eofc/Data broadcast
//   smiReq*          downstream request port (Ready/Eofc/Data out, Stop in)
//   smiResp*         downstream response port (Ready/Eofc/Data in, Stop out)
//
// States:
//   state | meaning
//   IDLE  | arbitration bubble; all requesters stalled, pick next grant
//   FWD   | granted requester's frame passes straight through downstream
//   RIDLE | waiting for a response header; route taken from its tag
//   RFWD  | response body passes through to the latched route
// -----------------------------------------------------------------------------
module smi_request_arbiter_x4 #(
  parameter int FlitWidth      = 16,
  parameter int MaxOutstanding = 8,
  parameter int CountWidth     = 4
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic [3:0]                 smiInReqReady,
  input  logic [31:0]                smiInReqEofc,
  input  logic [4*FlitWidth*8-1:0]   smiInReqData,
  output logic [3:0]                 smiInReqStop,
  output logic [3:0]                 smiInRespReady,
  output logic [7:0]                 smiInRespEofc,
  output logic [FlitWidth*8-1:0]     smiInRespData,
  input  logic [3:0]                 smiInRespStop,
  output logic                       smiReqReady,
  output logic [7:0]                 smiReqEofc,
  output logic [FlitWidth*8-1:0]     smiReqData,
  input  logic                       smiReqStop,
  input  logic                       smiRespReady,
  input  logic [7:0]                 smiRespEofc,
  input  logic [FlitWidth*8-1:0]     smiRespData,
  output logic                       smiRespStop
);

  localparam int DW = FlitWidth * 8;

  typedef enum logic {IDLE, FWD}   req_state_t;
  typedef enum logic {RIDLE, RFWD} resp_state_t;

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  req_state_t    req_state, req_state_next;
  logic [1:0]    ptr, ptr_next;
  logic [1:0]    grant, grant_next;
  logic          first_flit, first_flit_next;
  logic          credit_ok;
  logic          req_xfer;
  logic [1:0]    pick;
  logic          any_req;
  logic [DW-1:0] grant_data;
  logic [7:0]    grant_eofc;
  logic          grant_ready;

  // Scan from the pointer upward; iterating offsets high-to-low lets the
  // smallest offset (closest to the pointer) win.
  always_comb begin
    pick    = ptr;
    any_req = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (smiInReqReady[ptr + 2'(k)]) begin
        pick    = ptr + 2'(k);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    grant_data  = smiInReqData[int'(grant)*DW +: DW];
    grant_eofc  = smiInReqEofc[int'(grant)*8 +: 8];
    grant_ready = smiInReqReady[grant];
  end

  always_comb begin
    req_state_next  = req_state;
    ptr_next        = ptr;
    grant_next      = grant;
    first_flit_next = first_flit;
    req_xfer        = 1'b0;
    smiInReqStop    = 4'hF;
    smiReqReady     = 1'b0;
    smiReqEofc      = grant_eofc;
    smiReqData      = grant_data;
    // Header flit carries the requester index in byte 1 so the response can
    // find its way back.
    if (first_flit) begin
      smiReqData[15:8] = {6'b0, grant};
    end
    case (req_state)
      IDLE: begin
        if (any_req && credit_ok) begin
          grant_next      = pick;
          first_flit_next = 1'b1;
          req_state_next  = FWD;
        end
      end
      FWD: begin
        smiReqReady         = grant_ready;
        smiInReqStop[grant] = smiReqStop;
        req_xfer            = grant_ready && !smiReqStop;
        if (req_xfer) begin
          first_flit_next = 1'b0;
          if (grant_eofc != 8'h00) begin
            ptr_next       = grant + 2'd1;
            req_state_next = IDLE;
          end
        end
      end
      default: req_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      req_state  <= IDLE;
      ptr        <= 2'd0;
      grant      <= 2'd0;
      first_flit <= 1'b0;
    end else begin
      req_state  <= req_state_next;
      ptr        <= ptr_next;
      grant      <= grant_next;
      first_flit <= first_flit_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  resp_state_t resp_state, resp_state_next;
  logic [1:0]  route, route_next, route_sel;
  logic        resp_xfer;

  assign smiInRespEofc = smiRespEofc;
  assign smiInRespData = smiRespData;

  always_comb begin
    resp_state_next = resp_state;
    route_next      = route;
    route_sel       = (resp_state == RFWD) ? route : smiRespData[9:8];
    smiInRespReady  = 4'h0;
    smiRespStop     = 1'b1;
    // Passthrough is combinational, so it is gated explicitly to present
    // quiet outputs while reset is held.
    if (arstn) begin
      smiInRespReady[route_sel] = smiRespReady;
      smiRespStop               = smiInRespStop[route_sel];
    end
    resp_xfer = smiRespReady && !smiRespStop;
    case (resp_state)
      RIDLE: begin
        // Single-flit responses never leave RIDLE.
        if (resp_xfer && (smiRespEofc == 8'h00)) begin
          route_next      = route_sel;
          resp_state_next = RFWD;
        end
      end
      RFWD: begin
        if (resp_xfer && (smiRespEofc != 8'h00)) begin
          resp_state_next = RIDLE;
        end
      end
      default: resp_state_next = RIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      resp_state <= RIDLE;
      route      <= 2'd0;
    end else begin
      resp_state <= resp_state_next;
      route      <= route_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding-frame limit
  // ---------------------------------------------------------------------------
`ifdef SMI_ARB_OUTSTANDING_LIMIT_EN
  localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxOutstanding);

  logic [CountWidth-1:0] outstanding;
  logic                  cnt_inc;
  logic                  cnt_dec;

  assign cnt_inc   = req_xfer && first_flit;
  // A final response flit with nothing outstanding is ignored (no underflow).
  assign cnt_dec   = resp_xfer && (smiRespEofc != 8'h00) && (outstanding != '0);
  assign credit_ok = (outstanding != MaxCount);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      outstanding <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      outstanding <= outstanding + CountWidth'(1);
    end else if (cnt_dec && !cnt_inc) begin
      outstanding <= outstanding - CountWidth'(1);
    end
  end
`else
  logic unused_cfg;

  assign credit_ok  = 1'b1;
  assign unused_cfg = (MaxOutstanding > 0) ^ (CountWidth > 0);
`endif

endmodule

// File: tb/tb_smi_request_arbiter_x4.sv
`timescale 1ns/1ps
module tb_smi_request_arbiter_x4;

  localparam int FW   = 16;
  localparam int DW   = FW * 8;
  localparam int MAXO = 2;
`ifdef SMI_ARB_OUTSTANDING_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    eofc;
  } flit_t;

  logic            clk = 1'b0;
  logic            arstn = 1'b0;
  logic [3:0]      in_ready = '0;
  logic [31:0]     in_eofc = '0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]      in_stop;
  logic [3:0]      in_resp_ready;
  logic [7:0]      in_resp_eofc;
  logic [DW-1:0]   in_resp_data;
  logic [3:0]      in_resp_stop = '0;
  logic            req_ready;
  logic [7:0]      req_eofc;
  logic [DW-1:0]   req_data;
  logic            req_stop = 1'b0;
  logic            resp_ready = 1'b0;
  logic [7:0]      resp_eofc = '0;
  logic [DW-1:0]   resp_data = '0;
  logic            resp_stop;

  always #5 clk = ~clk;

  smi_request_arbiter_x4 #(
    .FlitWidth(FW), .MaxOutstanding(MAXO), .CountWidth(4)
  ) dut (
    .clk(clk), .arstn(arstn),
    .smiInReqReady(in_ready), .smiInReqEofc(in_eofc), .smiInReqData(in_data),
    .smiInReqStop(in_stop),
    .smiInRespReady(in_resp_ready), .smiInRespEofc(in_resp_eofc),
    .smiInRespData(in_resp_data), .smiInRespStop(in_resp_stop),
    .smiReqReady(req_ready), .smiReqEofc(req_eofc), .smiReqData(req_data),
    .smiReqStop(req_stop),
    .smiRespReady(resp_ready), .smiRespEofc(resp_eofc), .smiRespData(resp_data),
    .smiRespStop(resp_stop)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: per-requester flit queues, one response queue, and the
  // arbitration rules (who owns the downstream port, where the pointer is,
  // which requester a response belongs to, how many frames are in flight).
  flit_t      rq[4][$];
  flit_t      sq[$];
  logic [1:0] hdr_log[$];
  bit         m_busy = 0, m_first = 0, m_rbusy = 0;
  int         m_grant = 0, m_ptr = 0, m_rroute = 0, m_cnt = 0;
  int         gap_pct = 0, stop_pct = 0, rstop_pct = 0;
  bit         auto_resp = 1;

  function automatic logic [DW-1:0] rand_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic add_req_frame(input int r, input int n, input logic [7:0] byte1);
    flit_t f;
    for (int i = 0; i < n; i++) begin
      f.data = rand_flit();
      if (i == 0) f.data[15:8] = byte1;
      f.eofc = (i == n - 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      rq[r].push_back(f);
    end
  endtask

  task automatic add_resp_frame(input logic [7:0] byte1, input int n);
    flit_t f;
    for (int i = 0; i < n; i++) begin
      f.data = rand_flit();
      if (i == 0) f.data[15:8] = byte1;
      f.eofc = (i == n - 1) ? 8'($urandom_range(255, 1)) : 8'h00;
      sq.push_back(f);
    end
  endtask

  function automatic int pending();
    int n = sq.size();
    for (int r = 0; r < 4; r++) n += rq[r].size();
    return n;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 4; r++) rq[r].delete();
    sq.delete();
    m_busy = 0; m_first = 0; m_rbusy = 0;
    m_grant = 0; m_ptr = 0; m_rroute = 0; m_cnt = 0;
  endtask

  task automatic drive();
    logic [3:0] rdy = '0;
    for (int r = 0; r < 4; r++) begin
      if (rq[r].size() > 0) begin
        in_data[r*DW +: DW] = rq[r][0].data;
        in_eofc[r*8 +: 8]   = rq[r][0].eofc;
        rdy[r] = ($urandom_range(99) >= gap_pct);
      end else begin
        in_data[r*DW +: DW] = rand_flit();
        in_eofc[r*8 +: 8]   = 8'($urandom);
      end
    end
    in_ready = rdy;
    req_stop = ($urandom_range(99) < stop_pct);
    if (sq.size() > 0) begin
      resp_ready = ($urandom_range(99) >= gap_pct);
      resp_data  = sq[0].data;
      resp_eofc  = sq[0].eofc;
    end else begin
      resp_ready = 1'b0;
      resp_data  = rand_flit();
      resp_eofc  = 8'($urandom);
    end
    for (int r = 0; r < 4; r++) in_resp_stop[r] = ($urandom_range(99) < rstop_pct);
  endtask

  task automatic check_cycle();
    logic [3:0]    exp_stop;
    logic [DW-1:0] exp_d;
    logic [1:0]    dest;
    flit_t         f;
    int            g;
    bit            inc = 0, dec = 0, found = 0;
    if (!m_busy) begin
      chk("idle_req_ready", DW'(req_ready), '0);
      chk("idle_in_stop", DW'(in_stop), DW'(4'hF));
      if (in_ready != 4'h0 && (!LIMIT || m_cnt < MAXO)) begin
        for (int k = 0; k < 4; k++) begin
          if (!found && in_ready[(m_ptr + k) % 4]) begin
            m_grant = (m_ptr + k) % 4;
            found = 1;
          end
        end
        m_busy = 1; m_first = 1;
      end
    end else begin
      g = m_grant;
      chk("req_ready", DW'(req_ready), DW'(in_ready[g]));
      exp_stop = 4'hF;
      exp_stop[g] = req_stop;
      chk("in_stop", DW'(in_stop), DW'(exp_stop));
      if (in_ready[g]) begin
        f = rq[g][0];
        exp_d = f.data;
        if (m_first) exp_d[15:8] = {6'b0, 2'(g)};
        chk("req_data", req_data, exp_d);
        chk("req_eofc", DW'(req_eofc), DW'(f.eofc));
        if (!req_stop) begin
          f = rq[g].pop_front();
          if (m_first) begin
            hdr_log.push_back(req_data[9:8]);
            inc = 1;
          end
          m_first = 0;
          if (f.eofc != 8'h00) begin
            m_busy = 0;
            m_ptr = (g + 1) % 4;
          end
        end
      end
    end
    dest = m_rbusy ? 2'(m_rroute) : resp_data[9:8];
    chk("resp_ready", DW'(in_resp_ready), DW'(resp_ready ? (4'b0001 << dest) : 4'b0000));
    chk("resp_stop", DW'(resp_stop), DW'(in_resp_stop[dest]));
    chk("resp_data", in_resp_data, resp_data);
    chk("resp_eofc", DW'(in_resp_eofc), DW'(resp_eofc));
    if (resp_ready && !in_resp_stop[dest]) begin
      f = sq.pop_front();
      if (!m_rbusy && f.eofc == 8'h00) begin
        m_rbusy = 1;
        m_rroute = int'(dest);
      end else if (m_rbusy && f.eofc != 8'h00) begin
        m_rbusy = 0;
      end
      if (f.eofc != 8'h00 && m_cnt > 0) dec = 1;
    end
    if (inc && !dec) m_cnt++;
    else if (dec && !inc) m_cnt--;
    if (LIMIT && auto_resp && inc) add_resp_frame({6'b0, 2'(g)}, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", DW'(pending()), '0);
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_stop"}, DW'(in_stop), DW'(4'hF));
    chk({tag, "_req_ready"}, DW'(req_ready), '0);
    chk({tag, "_resp_ready"}, DW'(in_resp_ready), '0);
    chk({tag, "_resp_stop"}, DW'(resp_stop), DW'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with traffic offered on every input.
    in_ready = 4'hF;
    resp_ready = 1'b1;
    #3;
    check_reset_outputs("rst");
    in_ready = 4'h0;
    resp_ready = 1'b0;
    @(negedge clk);
    arstn = 1'b1;

    // All four requesters with back-to-back 2-flit frames: strict rotation.
    hdr_log.delete();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++) add_req_frame(r, 2, 8'($urandom));
    run_until_empty(200);
    chk("rr_count", DW'(hdr_log.size()), DW'(8));
    for (int i = 0; i < hdr_log.size(); i++) chk("rr_order", DW'(hdr_log[i]), DW'(i % 4));

    // Requester 2, 3-flit frame, header byte1 0xAA is retagged; pointer -> 3.
    hdr_log.delete();
    add_req_frame(2, 3, 8'hAA);
    run_until_empty(50);
    for (int r = 0; r < 4; r++) add_req_frame(r, 1, 8'($urandom));
    run_until_empty(50);
    chk("hdr_tag2", DW'(hdr_log[0]), DW'(2));
    chk("ptr_after2", DW'(hdr_log[1]), DW'(3));

    // Downstream stall mid-frame from requester 1; others arrive during stall.
    hdr_log.delete();
    add_req_frame(1, 4, 8'h55);
    step();
    step();
    stop_pct = 100;
    add_req_frame(0, 1, 8'h11);
    add_req_frame(2, 1, 8'h22);
    add_req_frame(3, 1, 8'h33);
    repeat (4) step();
    stop_pct = 0;
    run_until_empty(100);
    chk("stall_owner", DW'(hdr_log[0]), DW'(1));
    chk("stall_next", DW'(hdr_log[1]), DW'(2));

    // Response routing: tag 3 with toggling stop, then tag 1 with junk high bits.
    rstop_pct = 50;
    add_resp_frame(8'h03, 4);
    add_resp_frame(8'hFD, 3);
    add_resp_frame(8'h02, 1);
    run_until_empty(200);
    rstop_pct = 0;

    // Reset mid-frame on both paths.
    add_req_frame(1, 4, 8'h00);
    add_resp_frame(8'h02, 4);
    begin
      int n = 0;
      while (!(m_busy && !m_first && m_rbusy) && n < 20) begin
        step();
        n++;
      end
      chk("mid_frame_reached", DW'(m_busy && !m_first && m_rbusy), DW'(1'b1));
    end
    #2;
    arstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      drive();
    end
    @(negedge clk);
    arstn = 1'b1;
    hdr_log.delete();
    for (int r = 0; r < 4; r++) add_req_frame(r, 2, 8'($urandom));
    run_until_empty(100);
    chk("post_rst_first", DW'(hdr_log[0]), DW'(0));

`ifdef SMI_ARB_OUTSTANDING_LIMIT_EN
    // Outstanding limit of 2: third frame waits until one response completes.
    @(negedge clk);
    arstn = 1'b0;
    model_reset();
    @(negedge clk);
    arstn = 1'b1;
    auto_resp = 0;
    hdr_log.delete();
    add_req_frame(0, 1, 8'h00);
    add_req_frame(1, 1, 8'h00);
    add_req_frame(2, 1, 8'h00);
    repeat (12) step();
    chk("limit_fwd", DW'(hdr_log.size()), DW'(2));
    chk("limit_wait", DW'(rq[2].size()), DW'(1));
    add_resp_frame(8'h00, 1);
    run_until_empty(50);
    chk("limit_release", DW'(hdr_log.size()), DW'(3));
    auto_resp = 1;
`endif

    // Randomized mixed traffic on both paths.
    for (int it = 0; it < 1500; it++) begin
      if (it % 100 == 0) begin
        gap_pct   = $urandom_range(30);
        stop_pct  = $urandom_range(40);
        rstop_pct = $urandom_range(40);
      end
      if ($urandom_range(99) < 15) begin
        int r = $urandom_range(3);
        if (rq[r].size() < 8) add_req_frame(r, $urandom_range(4, 1), 8'($urandom));
      end
      if ($urandom_range(99) < 10 && sq.size() < 8)
        add_resp_frame(8'($urandom), $urandom_range(4, 1));
      step();
    end
    gap_pct = 0; stop_pct = 0; rstop_pct = 0;
    run_until_empty(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
